// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results go straight to the RF write port; LSU results queue in a FIFO and drain when the ALU is idle.
// Define WB_SCOREBOARD_EN to build the pending-write scoreboard; otherwise pending is tied to zero.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        issue_long,
    input  logic [4:0]  issue_rd,
    output logic        stall_req,
    output logic [31:0] pending,
    output logic        regwrite,
    output logic [4:0]  ad3,
    output logic [31:0] wd3
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t     mem [DEPTH];
    wb_ent_t     head;
    logic [AW:0] wptr, rptr, count;
    logic        full, empty, push, pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign count     = wptr - rptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign lsu_ready = !full && !rst;
    assign stall_req = full;
    assign push      = lsu_valid && lsu_ready;
    assign pop       = !alu_valid && !empty;
    assign head      = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= '{rd: lsu_rd, data: lsu_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // x0 targets still take the port slot and pop, but never assert the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite <= 1'b0;
            ad3      <= '0;
            wd3      <= '0;
        end else if (alu_valid) begin
            regwrite <= (alu_rd != '0);
            ad3      <= alu_rd;
            wd3      <= alu_result;
        end else if (pop) begin
            regwrite <= (head.rd != '0);
            ad3      <= head.rd;
            wd3      <= head.data;
        end else begin
            regwrite <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] sb_q, sb_set, sb_clr;

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (issue_long) sb_set = 32'd1 << issue_rd;
        if (pop)        sb_clr = 32'd1 << head.rd;
    end

    // Set is OR'd after the clear so a newer issue survives a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) sb_q <= '0;
        else     sb_q <= ((sb_q & ~sb_clr) | sb_set) & ~32'd1;
    end

    assign pending = sb_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_long, issue_rd};
    assign pending      = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter, checked every cycle against a queue-based model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        issue_long = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        stall_req;
    logic [31:0] pending;
    logic        regwrite;
    logic [4:0]  ad3;
    logic [31:0] wd3;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_long(issue_long), .issue_rd(issue_rd),
        .stall_req(stall_req), .pending(pending),
        .regwrite(regwrite), .ad3(ad3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue of {rd,data}, pending as a plain bit vector.
    logic [36:0] q[$];
    logic [31:0] m_pend = '0;
    logic        m_rw = 1'b0;
    logic [4:0]  m_ad = '0;
    logic [31:0] m_wd = '0;
    logic        m_rst = 1'b0;

    always @(posedge clk) begin
        logic [36:0] e;
        logic        pushed;
        m_rst = rst;
        if (rst) begin
            q.delete();
            m_pend = '0;
            m_rw = 1'b0; m_ad = '0; m_wd = '0;
        end else begin
            pushed = lsu_valid && (q.size() < DEPTH);
            m_rw = 1'b0;
            if (alu_valid) begin
                m_rw = (alu_rd != 0); m_ad = alu_rd; m_wd = alu_result;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_rw = (e[36:32] != 0); m_ad = e[36:32]; m_wd = e[31:0];
                if (e[36:32] != 0) m_pend[e[36:32]] = 1'b0;
            end
            if (pushed) q.push_back({lsu_rd, lsu_data});
            if (issue_long && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        #1;
        chk("regwrite", {31'd0, regwrite}, {31'd0, m_rw});
        if (m_rw || m_rst) begin
            chk("ad3", {27'd0, ad3}, {27'd0, m_ad});
            chk("wd3", wd3, m_wd);
        end
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !rst && (q.size() < DEPTH)});
        chk("stall_req", {31'd0, stall_req}, {31'd0, q.size() == DEPTH});
        chk("pending", pending, SB ? m_pend : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_long = 1'b0; rst = 1'b0;
    endtask

    int idx;
    bit acc;

    initial begin
        logic [4:0]  frd[5];
        logic [31:0] fdat[5];
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation
        @(negedge clk);
        alu_valid = 1; alu_rd = 2; alu_result = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        issue_long = 1; issue_rd = 4;
        tick();
        @(negedge clk);
        idle(); rst = 1'b1;
        tick();
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        chk("post_rst_no_write", {31'd0, regwrite}, 32'd0);

        // ALU only
        @(negedge clk);
        alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
        tick();
        chk("alu_rw", {31'd0, regwrite}, 32'd1);
        chk("alu_ad3", {27'd0, ad3}, 32'd5);
        chk("alu_wd3", wd3, 32'hDEADBEEF);

        // Arbitration: ALU wins, LSU lands one cycle later
        @(negedge clk);
        alu_valid = 1; alu_rd = 3; alu_result = 32'h55;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
        issue_long = 1; issue_rd = 7;
        tick();
        chk("arb_first_ad3", {27'd0, ad3}, 32'd3);
        chk("arb_first_wd3", wd3, 32'h55);
        chk("arb_pend7_set", {31'd0, pending[7]}, {31'd0, SB});
        @(negedge clk);
        idle();
        tick();
        chk("arb_second_rw", {31'd0, regwrite}, 32'd1);
        chk("arb_second_ad3", {27'd0, ad3}, 32'd7);
        chk("arb_second_wd3", wd3, 32'h1234);
        chk("arb_pend7_clr", {31'd0, pending[7]}, 32'd0);

        // Full / backpressure: ALU held high, 5 LSU results offered
        for (int i = 0; i < 5; i++) begin
            frd[i] = 5'(10 + i); fdat[i] = 32'hA000 + i;
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            alu_valid = 1; alu_rd = 1; alu_result = 32'(c);
            lsu_valid = 1; lsu_rd = frd[idx]; lsu_data = fdat[idx];
            #1 acc = lsu_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        chk("full_pushes", 32'(idx), 32'd4);
        chk("full_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("full_stall_req", {31'd0, stall_req}, 32'd1);
        alu_valid = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (c > 0) @(negedge clk);
            lsu_valid = 1; lsu_rd = frd[idx]; lsu_data = fdat[idx];
            #1 acc = lsu_ready;
            @(posedge clk);
            if (acc) idx++;
            #2;
            if (c == 0) chk("drain_first_ad3", {27'd0, ad3}, 32'd10);
        end
        chk("fifth_accepted", 32'(idx), 32'd5);
        @(negedge clk);
        idle();
        repeat (6) tick();

        // x0 and scoreboard corners
        @(negedge clk);
        issue_long = 1; issue_rd = 0;
        tick();
        chk("x0_issue_pending", pending, 32'd0);
        @(negedge clk);
        issue_long = 0; lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD;
        tick();
        @(negedge clk);
        lsu_valid = 0;
        tick();
        chk("x0_pop_rw", {31'd0, regwrite}, 32'd0);
        @(negedge clk);
        issue_long = 1; issue_rd = 9;
        alu_valid = 1; alu_rd = 1; alu_result = 32'h1;
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
        tick();
        @(negedge clk);
        alu_valid = 0; lsu_valid = 0; issue_long = 1; issue_rd = 9;
        tick();
        chk("set_wins_ad3", {27'd0, ad3}, 32'd9);
        chk("set_wins_pend9", {31'd0, pending[9]}, {31'd0, SB});
        @(negedge clk);
        idle();
        tick();

        // Random traffic with LSU hold-until-accepted protocol
        acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_result = $urandom;
            if (!lsu_valid || acc) begin
                lsu_valid = ($urandom_range(0, 1) == 1);
                lsu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                lsu_data = $urandom;
            end
            issue_long = ($urandom_range(0, 9) < 3);
            issue_rd = 5'($urandom);
            #1 acc = lsu_valid && lsu_ready;
        end
        @(negedge clk);
        idle();
        repeat (8) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
